// File: rtl/rv32imf_data_obi_arbiter.sv
// Two-port arbiter sharing the data-side OBI bus, with an in-order owner FIFO for response routing.
// Define RV32IMF_ARB_ROUND_ROBIN_EN for round-robin contention; fixed priority (port 0) otherwise.
module rv32imf_data_obi_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int PAYLOAD_W       = 75
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m0_req_i,
    output logic                 m0_gnt_o,
    input  logic [PAYLOAD_W-1:0] m0_payload_i,
    output logic                 m0_rvalid_o,
    input  logic                 m1_req_i,
    output logic                 m1_gnt_o,
    input  logic [PAYLOAD_W-1:0] m1_payload_i,
    output logic                 m1_rvalid_o,
    output logic [31:0]          resp_rdata_o,
    output logic                 resp_err_o,
    output logic                 obi_req_o,
    input  logic                 obi_gnt_i,
    output logic [PAYLOAD_W-1:0] obi_payload_o,
    input  logic                 obi_rvalid_i,
    input  logic [31:0]          obi_rdata_i,
    input  logic                 obi_err_i,
    output logic                 protocol_err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    logic [CNT_W-1:0] cnt_q;
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    port_e            fifo_q [MAX_OUTSTANDING];
    logic             lock_q;
    port_e            lock_owner_q;
    port_e            rr_q;
    logic             protocol_err_q;

    port_e owner;
    port_e head;
    logic  space, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        owner = PORT0;
        if (lock_q)
            owner = lock_owner_q;
        else if (m0_req_i && m1_req_i)
            owner = rr_q;
        else if (m1_req_i)
            owner = PORT1;
    end

    // A response freed this cycle only opens space on the next one.
    assign space         = (cnt_q < CNT_MAX);
    assign obi_req_o     = space && (lock_q || m0_req_i || m1_req_i);
    assign obi_payload_o = (owner == PORT1) ? m1_payload_i : m0_payload_i;
    assign push          = obi_req_o && obi_gnt_i;
    assign m0_gnt_o      = push && (owner == PORT0);
    assign m1_gnt_o      = push && (owner == PORT1);

    assign head        = fifo_q[rd_ptr_q];
    assign pop         = obi_rvalid_i && (cnt_q != '0);
    assign m0_rvalid_o = pop && (head == PORT0);
    assign m1_rvalid_o = pop && (head == PORT1);

    assign resp_rdata_o   = obi_rdata_i;
    assign resp_err_o     = obi_err_i;
    assign protocol_err_o = protocol_err_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            lock_q         <= 1'b0;
            lock_owner_q   <= PORT0;
            protocol_err_q <= 1'b0;
        end else begin
            if (obi_req_o) begin
                lock_q       <= !obi_gnt_i;
                lock_owner_q <= owner;
            end
            if (push)
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)
                cnt_q <= cnt_q + CNT_W'(1);
            else if (pop && !push)
                cnt_q <= cnt_q - CNT_W'(1);
            if (obi_rvalid_i && (cnt_q == '0))
                protocol_err_q <= 1'b1;
        end
    end

    // NOTE: owner storage is not reset; only entries between the pointers, counted by cnt_q, are ever used.
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr_q] <= owner;
    end

`ifdef RV32IMF_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_q <= PORT0;
        else if (push)
            rr_q <= port_e'(~owner);
    end
`else
    assign rr_q = PORT0;
`endif

endmodule

// File: doc/rv32imf_data_obi_arbiter.md
# rv32imf_data_obi_arbiter

Two-requester arbiter that shares the single data-side OBI port between the core load/store unit (port 0) and a secondary master such as a debug/system-bus access unit (port 1). It grants at most one request per cycle and holds the arbitration decision stable while a request waits for grant. It tracks the owner of every granted, outstanding transaction in an in-order ID FIFO, and routes each response back to the requester that issued it.

## Interface
- MAX_OUTSTANDING, default 2: depth of the owner FIFO; legal values 1..4.
- PAYLOAD_W, default 75: request payload width, packed {atop[5:0], wdata[31:0], be[3:0], we, addr[31:0]}, with addr at the LSBs.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- m0_req_i  input  1  port 0 request; held with stable payload until m0_gnt_o.
- m0_gnt_o  output  1  port 0 grant.
- m0_payload_i  input  PAYLOAD_W  port 0 request payload.
- m0_rvalid_o  output  1  port 0 response valid.
- m1_req_i  input  1  port 1 request; held with stable payload until m1_gnt_o.
- m1_gnt_o  output  1  port 1 grant.
- m1_payload_i  input  PAYLOAD_W  port 1 request payload.
- m1_rvalid_o  output  1  port 1 response valid.
- resp_rdata_o  output  32  response data, broadcast to both ports (= obi_rdata_i).
- resp_err_o  output  1  response error, broadcast (= obi_err_i).
- obi_req_o  output  1  downstream request.
- obi_gnt_i  input  1  downstream grant.
- obi_payload_o  output  PAYLOAD_W  downstream payload, muxed from the owner.
- obi_rvalid_i  input  1  downstream response valid.
- obi_rdata_i  input  32  downstream read data.
- obi_err_i  input  1  downstream bus error.
- protocol_err_o  output  1  sticky flag: rvalid seen with no outstanding transaction.

## Operation
- State:
  - cnt_q, width $clog2(MAX_OUTSTANDING+1).
  - Owner FIFO of 1-bit IDs, with rd/wr pointers.
  - lock_q and lock_owner_q.
  - rr_q, the priority pointer.
  - protocol_err_q.
- Space check: space = (cnt_q < MAX_OUTSTANDING). obi_rvalid_i does not create space in the same cycle.
- Owner selection:
  - If lock_q is set, the owner is lock_owner_q.
  - Otherwise, if exactly one mX_req_i is high, that port is the owner.
  - If both are high, the owner is the port given by the priority policy (see Configuration).
- Request path:
  - obi_req_o = space && (lock_q || m0_req_i || m1_req_i).
  - obi_payload_o = the owner's payload. With no request, it is m0_payload_i.
  - mX_gnt_o = obi_gnt_i && obi_req_o && owner==X. At most one grant per cycle.
- Lock:
  - Set when obi_req_o && !obi_gnt_i; lock_owner_q <= owner.
  - Cleared on obi_gnt_i. A port may not retract its request while locked. If it does, obi_req_o stays high regardless.
- On a grant: push the owner ID and cnt_q++.
- On obi_rvalid_i:
  - If cnt_q>0: pop the head, assert m{head}_rvalid_o the same cycle, and cnt_q--.
  - If cnt_q==0: drop the response; protocol_err_q <= 1, cleared only by reset.
- Simultaneous grant and rvalid: push and pop together, cnt_q unchanged. The pop uses the old head, so it is correct even when the FIFO was holding one entry.
- Pointers wrap modulo MAX_OUTSTANDING.

## Timing
- Request and grant paths are combinational: zero-cycle arbitration, grant in the same cycle as obi_gnt_i.
- Response routing is combinational from obi_rvalid_i. resp_rdata_o and resp_err_o are pure pass-through.
- Reset values:
  - State: cnt_q=0, FIFO empty, lock_q=0, lock_owner_q=0, rr_q=0 (port 0 favoured), protocol_err_o=0.
  - Outputs: all gnt/rvalid/obi_req_o outputs are 0 with inputs idle.
- Full FIFO (cnt_q==MAX_OUTSTANDING): obi_req_o=0 and no grants. Requests resume the cycle after an rvalid.
- Reset mid-transaction: all state clears asynchronously. Responses arriving later for pre-reset transactions set protocol_err_o and are dropped.

## Configuration
- RV32IMF_ARB_ROUND_ROBIN_EN defined:
  - Contention goes to port rr_q.
  - On each grant, rr_q <= ~granted_port.
- RV32IMF_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority, port 0 always wins contention.
  - rr_q is absent, held at 0.

## Test plan
- Single access: m0 req addr 0x100, gnt same cycle → m0_gnt_o=1 and cnt=1. Then rvalid with rdata 0xDEADBEEF → m0_rvalid_o=1, m1_rvalid_o=0, resp_rdata_o=0xDEADBEEF, cnt=0.
- Contention with round robin, gnt tied high and both requesting for 4 cycles → grants m0,m1,m0,m1. Without the macro → m0 four times.
- Lock: m1 requests alone, gnt low for 3 cycles, then m0 also requests → obi_payload_o stays m1's. On gnt, m1_gnt_o=1 and m0_gnt_o=0.
- Full and interleave, MAX_OUTSTANDING=2: grant m0 then m1 → obi_req_o=0 while full. rvalids route m0 then m1, in order.
- Simultaneous: cnt=1 (owner m0), m1 granted in the same cycle as rvalid → m0_rvalid_o=1, cnt stays 1. The next rvalid goes to m1.
- Spurious response: obi_rvalid_i with cnt=0 → no mX_rvalid_o, protocol_err_o=1 until rst_n low.
